// File: rtl/seek_agc_ctrl.sv
// seek_agc_ctrl: averages the envelope level over fixed windows and uses it for
// a gain AGC loop, a stepping station seek on the NCO word, and SPI pass-through.
module seek_agc_ctrl #(
  parameter logic [15:0] STEP       = 16'd64,
  parameter int          MAX_STEPS  = 1024,
  parameter int          SETTLE_CYC = 4096,
  parameter int          WIN_LOG2   = 12,
  parameter logic [7:0]  SEEK_TH    = 8'd48,
  parameter logic [7:0]  AGC_HI     = 8'd200,
  parameter logic [7:0]  AGC_LO     = 8'd40
) (
  input  logic        clk,
  input  logic        RSTb,
  input  logic [15:0] spi_phase_inc,
  input  logic [2:0]  spi_gain,
  input  logic        spi_load,
  input  logic [7:0]  env_in,
  input  logic        seek_start,
  input  logic        seek_dir,
  input  logic        agc_en,
  output logic [15:0] phase_inc,
  output logic [2:0]  gain,
  output logic        busy,
  output logic        found,
  output logic [7:0]  level
);

  localparam int ACC_W = 8 + WIN_LOG2;
  localparam int SC_W  = $clog2(MAX_STEPS + 1);
  localparam int ST_W  = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STEP, ST_SETTLE, ST_MEASURE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ACC_W-1:0]    accum;
  logic [ACC_W-1:0]    win_sum;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [7:0]          win_level;
  logic                meas_run;
  logic                eng_clr;
  logic                win_done;
  logic [ST_W-1:0]     settle_cnt;
  logic                settle_done;
  logic [SC_W-1:0]     step_cnt;
  logic                steps_out;
  logic                seek_hit;
  logic [15:0]         start_pi;
  logic                seek_up;
  logic                do_load;
  logic                do_start;
  logic                do_step;
  logic                do_hit;
  logic                do_miss;
  logic                do_agc;

  function automatic logic [7:0] win_mean(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:WIN_LOG2];
  endfunction

  // Saturating one-step gain move: too loud backs off, too quiet opens up.
  function automatic logic [2:0] agc_next(input logic [2:0] g, input logic [7:0] lvl);
    if (lvl > AGC_HI && g != 3'd0)
      return g - 3'd1;
    else if (lvl < AGC_LO && g != 3'd7)
      return g + 3'd1;
    return g;
  endfunction

  function automatic logic [15:0] step_pi(input logic [15:0] pi, input logic up);
    return up ? pi + STEP : pi - STEP;
  endfunction

  // Measurement engine: runs in IDLE/MEASURE, held cleared while retuning.
  assign meas_run  = (state == ST_IDLE) || (state == ST_MEASURE);
  assign eng_clr   = spi_load || !meas_run;
  assign win_done  = meas_run && !spi_load && (&win_cnt);
  assign win_sum   = accum + {{WIN_LOG2{1'b0}}, env_in};
  assign win_level = win_mean(win_sum);

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      accum   <= '0;
      win_cnt <= '0;
      level   <= '0;
    end else if (eng_clr) begin
      accum   <= '0;
      win_cnt <= '0;
    end else if (win_done) begin
      accum   <= '0;
      win_cnt <= '0;
      level   <= win_level;
    end else begin
      accum   <= win_sum;
      win_cnt <= win_cnt + WIN_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb)
      settle_cnt <= '0;
    else if (state == ST_SETTLE)
      settle_cnt <= settle_cnt + ST_W'(1);
    else
      settle_cnt <= '0;
  end

  assign settle_done = (settle_cnt == ST_W'(SETTLE_CYC - 1));
  assign steps_out   = (step_cnt == SC_W'(MAX_STEPS));
  assign seek_hit    = (win_level >= SEEK_TH);

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (!spi_load && seek_start) state_nxt = ST_STEP;
      ST_STEP:
        state_nxt = spi_load ? ST_IDLE : ST_SETTLE;
      ST_SETTLE:
        if (spi_load)         state_nxt = ST_IDLE;
        else if (settle_done) state_nxt = ST_MEASURE;
      ST_MEASURE:
        if (spi_load)                                 state_nxt = ST_IDLE;
        else if (win_done && (seek_hit || steps_out)) state_nxt = ST_IDLE;
        else if (win_done)                            state_nxt = ST_STEP;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // spi_load is honoured in every state; it doubles as the seek abort.
  always_comb begin
    do_load  = spi_load;
    do_start = 1'b0;
    do_step  = 1'b0;
    do_hit   = 1'b0;
    do_miss  = 1'b0;
    do_agc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        do_start = seek_start && !spi_load;
        do_agc   = win_done && agc_en && !seek_start;
      end
      ST_STEP:
        do_step = !spi_load;
      ST_MEASURE: begin
        do_hit  = win_done && seek_hit;
        do_miss = win_done && !seek_hit && steps_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      phase_inc <= '0;
      gain      <= '0;
      busy      <= 1'b0;
      found     <= 1'b0;
      start_pi  <= '0;
      seek_up   <= 1'b0;
      step_cnt  <= '0;
    end else if (do_load) begin
      phase_inc <= spi_phase_inc;
      if (!agc_en) gain <= spi_gain;
      busy      <= 1'b0;
      found     <= 1'b0;
    end else if (do_start) begin
      start_pi  <= phase_inc;
      seek_up   <= seek_dir;
      step_cnt  <= '0;
      busy      <= 1'b1;
      found     <= 1'b0;
    end else if (do_step) begin
      phase_inc <= step_pi(phase_inc, seek_up);
      step_cnt  <= step_cnt + SC_W'(1);
    end else if (do_hit) begin
      found     <= 1'b1;
      busy      <= 1'b0;
    end else if (do_miss) begin
      phase_inc <= start_pi;
      found     <= 1'b0;
      busy      <= 1'b0;
    end else if (do_agc) begin
      gain      <= agc_next(gain, win_level);
    end
  end

endmodule

// File: tb/tb_seek_agc_ctrl.sv
// Bench for seek_agc_ctrl: directed stimulus queues cycle-tagged expectations,
// an independent monitor pops and compares them on the falling clock edge.
module tb_seek_agc_ctrl;

  localparam logic [4:0] M_PH  = 5'b00001;
  localparam logic [4:0] M_G   = 5'b00010;
  localparam logic [4:0] M_B   = 5'b00100;
  localparam logic [4:0] M_F   = 5'b01000;
  localparam logic [4:0] M_LV  = 5'b10000;
  localparam logic [4:0] M_ALL = 5'b11111;

  logic        clk = 1'b0;
  logic        RSTb;
  logic [15:0] spi_phase_inc;
  logic [2:0]  spi_gain;
  logic        spi_load;
  logic [7:0]  env_in;
  logic        seek_start;
  logic        seek_dir;
  logic        agc_en;
  logic [15:0] phase_inc;
  logic [2:0]  gain;
  logic        busy;
  logic        found;
  logic [7:0]  level;

  logic [1:0]  env_mode;
  logic [7:0]  env_val;
  logic        alt = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [4:0]  m;
    logic [15:0] ph;
    logic [2:0]  g;
    logic        b;
    logic        f;
    logic [7:0]  lv;
  } exp_t;

  exp_t exp_q[$];

  seek_agc_ctrl #(
    .STEP(16'd64), .MAX_STEPS(4), .SETTLE_CYC(8), .WIN_LOG2(4),
    .SEEK_TH(8'd48), .AGC_HI(8'd200), .AGC_LO(8'd40)
  ) dut (
    .clk(clk), .RSTb(RSTb),
    .spi_phase_inc(spi_phase_inc), .spi_gain(spi_gain), .spi_load(spi_load),
    .env_in(env_in), .seek_start(seek_start), .seek_dir(seek_dir), .agc_en(agc_en),
    .phase_inc(phase_inc), .gain(gain), .busy(busy), .found(found), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) alt <= ~alt;

  // Envelope source: constant, 0/255 square wave, or a carrier at 0x10C0 only.
  always_comb begin
    case (env_mode)
      2'd1:    env_in = alt ? 8'd255 : 8'd0;
      2'd2:    env_in = (phase_inc == 16'h10C0) ? 8'd60 : 8'd10;
      default: env_in = env_val;
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int off, input string nm, input logic [4:0] m,
                           input logic [15:0] ph, input logic [2:0] g, input logic b,
                           input logic f, input logic [7:0] lv);
    exp_t e;
    e.cyc = cyc + off; e.name = nm; e.m = m;
    e.ph = ph; e.g = g; e.b = b; e.f = f; e.lv = lv;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        ok = 1'b1;
        if (e.m[0] && phase_inc !== e.ph) ok = 1'b0;
        if (e.m[1] && gain      !== e.g)  ok = 1'b0;
        if (e.m[2] && busy      !== e.b)  ok = 1'b0;
        if (e.m[3] && found     !== e.f)  ok = 1'b0;
        if (e.m[4] && level     !== e.lv) ok = 1'b0;
        if (e.cyc != cyc) begin
          n_errors++;
          $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end else if (!ok) begin
          n_errors++;
          $display("FAIL %s @%0d: got ph=%h g=%0d busy=%b found=%b lvl=%0d, want ph=%h g=%0d busy=%b found=%b lvl=%0d (mask %b)",
                   e.name, cyc, phase_inc, gain, busy, found, level,
                   e.ph, e.g, e.b, e.f, e.lv, e.m);
        end
      end
    end
  end

  initial begin
    RSTb = 1'b0; spi_phase_inc = '0; spi_gain = '0; spi_load = 1'b0;
    seek_start = 1'b0; seek_dir = 1'b0; agc_en = 1'b0; env_mode = 2'd0; env_val = 8'd0;
    tick(2);
    expect_at(0, "reset", M_ALL, 16'h0, 3'd0, 1'b0, 1'b0, 8'd0);
    tick(1);
    RSTb = 1'b1;
    tick(1);

    // Manual load, then window level from a constant and from a square wave
    spi_load = 1'b1; spi_phase_inc = 16'h1234; spi_gain = 3'd5; env_val = 8'd100;
    expect_at(1,  "load",     M_PH|M_G|M_B|M_F, 16'h1234, 3'd5, 1'b0, 1'b0, 8'd0);
    expect_at(16, "lvl_pre",  M_LV|M_G,         16'h0,    3'd5, 1'b0, 1'b0, 8'd0);
    expect_at(17, "lvl_100",  M_LV|M_PH|M_G,    16'h1234, 3'd5, 1'b0, 1'b0, 8'd100);
    tick(1); spi_load = 1'b0;
    tick(16);
    env_mode = 2'd1;
    expect_at(15, "lvl_hold", M_LV, 16'h0, 3'd0, 1'b0, 1'b0, 8'd100);
    expect_at(16, "lvl_alt",  M_LV, 16'h0, 3'd0, 1'b0, 1'b0, 8'd127);
    tick(16);

    // Seek up, carrier found on the third step
    spi_load = 1'b1; spi_phase_inc = 16'h1000; spi_gain = 3'd3; env_mode = 2'd2;
    expect_at(1, "hit_load", M_PH|M_G|M_B|M_F, 16'h1000, 3'd3, 1'b0, 1'b0, 8'd0);
    tick(1); spi_load = 1'b0; seek_start = 1'b1; seek_dir = 1'b1;
    tick(1); seek_start = 1'b0;
    expect_at(0,  "hit_busy", M_PH|M_B|M_F,      16'h1000, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(1,  "hit_s1",   M_PH|M_B,          16'h1040, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(25, "hit_s1_h", M_PH|M_B,          16'h1040, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(26, "hit_s2",   M_PH,              16'h1080, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(51, "hit_s3",   M_PH|M_G,          16'h10C0, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(74, "hit_pre",  M_PH|M_B|M_F|M_LV, 16'h10C0, 3'd3, 1'b1, 1'b0, 8'd10);
    expect_at(75, "hit_done", M_ALL,             16'h10C0, 3'd3, 1'b0, 1'b1, 8'd60);
    tick(75);

    // Seek up through the 16-bit wrap with no carrier: gives up and restores
    spi_load = 1'b1; spi_phase_inc = 16'hFFC0; spi_gain = 3'd3; env_mode = 2'd0; env_val = 8'd0;
    expect_at(1, "miss_load", M_PH|M_F|M_B, 16'hFFC0, 3'd3, 1'b0, 1'b0, 8'd0);
    tick(1); spi_load = 1'b0; seek_start = 1'b1; seek_dir = 1'b1;
    tick(1); seek_start = 1'b0;
    expect_at(0,   "miss_busy", M_B|M_F,  16'h0,    3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(1,   "miss_wrap", M_PH,     16'h0000, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(26,  "miss_s2",   M_PH,     16'h0040, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(51,  "miss_s3",   M_PH,     16'h0080, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(76,  "miss_s4",   M_PH,     16'h00C0, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(99,  "miss_last", M_PH|M_B, 16'h00C0, 3'd3, 1'b1, 1'b0, 8'd0);
    expect_at(100, "miss_done", M_ALL,    16'hFFC0, 3'd3, 1'b0, 1'b0, 8'd0);
    tick(100);

    // AGC: loud walks gain down to 0, quiet walks it up to 7, mid holds
    spi_load = 1'b1; spi_phase_inc = 16'h2000; spi_gain = 3'd2; env_val = 8'd250;
    expect_at(1, "agc_load", M_PH|M_G, 16'h2000, 3'd2, 1'b0, 1'b0, 8'd0);
    tick(1); spi_load = 1'b0; agc_en = 1'b1;
    expect_at(15, "agc_pre",   M_G,      16'h0, 3'd2, 1'b0, 1'b0, 8'd0);
    expect_at(16, "agc_dec1",  M_G|M_LV, 16'h0, 3'd1, 1'b0, 1'b0, 8'd250);
    expect_at(32, "agc_dec2",  M_G,      16'h0, 3'd0, 1'b0, 1'b0, 8'd0);
    expect_at(48, "agc_floor", M_G|M_LV, 16'h0, 3'd0, 1'b0, 1'b0, 8'd250);
    tick(48);
    env_val = 8'd10;
    expect_at(15,  "agc_lo_pre", M_G,      16'h0, 3'd0, 1'b0, 1'b0, 8'd0);
    expect_at(16,  "agc_inc1",   M_G|M_LV, 16'h0, 3'd1, 1'b0, 1'b0, 8'd10);
    expect_at(111, "agc_inc6",   M_G,      16'h0, 3'd6, 1'b0, 1'b0, 8'd0);
    expect_at(112, "agc_inc7",   M_G,      16'h0, 3'd7, 1'b0, 1'b0, 8'd0);
    expect_at(128, "agc_ceil",   M_G,      16'h0, 3'd7, 1'b0, 1'b0, 8'd0);
    tick(128);
    env_val = 8'd100;
    expect_at(16, "agc_mid", M_G|M_LV, 16'h0, 3'd7, 1'b0, 1'b0, 8'd100);
    tick(16);

    // Seek down with AGC enabled and a loud input: gain frozen while busy
    seek_start = 1'b1; seek_dir = 1'b0; env_val = 8'd250;
    tick(1); seek_start = 1'b0;
    expect_at(0,  "hold_busy",  M_B|M_G|M_F,  16'h0,    3'd7, 1'b1, 1'b0, 8'd0);
    expect_at(1,  "hold_down",  M_PH|M_G,     16'h1FC0, 3'd7, 1'b1, 1'b0, 8'd0);
    expect_at(24, "hold_meas",  M_G|M_B|M_LV, 16'h0,    3'd7, 1'b1, 1'b0, 8'd100);
    expect_at(25, "hold_hit",   M_ALL,        16'h1FC0, 3'd7, 1'b0, 1'b1, 8'd250);
    expect_at(41, "agc_resume", M_G|M_B|M_F,  16'h0,    3'd6, 1'b0, 1'b1, 8'd0);
    tick(41);

    // SPI load mid-SETTLE aborts the seek
    agc_en = 1'b0; seek_start = 1'b1; seek_dir = 1'b1; env_val = 8'd0;
    tick(1); seek_start = 1'b0;
    expect_at(0, "abort_busy",   M_B|M_F|M_PH, 16'h1FC0, 3'd6, 1'b1, 1'b0, 8'd0);
    expect_at(1, "abort_step",   M_PH,         16'h2000, 3'd6, 1'b1, 1'b0, 8'd0);
    expect_at(3, "abort_settle", M_PH|M_B|M_G, 16'h2000, 3'd6, 1'b1, 1'b0, 8'd0);
    tick(3);
    spi_load = 1'b1; spi_phase_inc = 16'h5555; spi_gain = 3'd4;
    expect_at(1,  "abort_load", M_PH|M_G|M_B|M_F, 16'h5555, 3'd4, 1'b0, 1'b0, 8'd0);
    expect_at(17, "abort_idle", M_PH|M_B|M_LV,    16'h5555, 3'd4, 1'b0, 1'b0, 8'd0);
    tick(1); spi_load = 1'b0;
    tick(16);

    // Reset dropped mid-MEASURE clears outputs before the next clock edge
    seek_start = 1'b1; seek_dir = 1'b1;
    tick(1); seek_start = 1'b0;
    expect_at(14, "rst_pre",   M_PH|M_B|M_G, 16'h5595, 3'd4, 1'b1, 1'b0, 8'd0);
    expect_at(15, "rst_async", M_ALL,        16'h0,    3'd0, 1'b0, 1'b0, 8'd0);
    tick(15);
    RSTb = 1'b0;
    tick(2);
    RSTb = 1'b1;
    expect_at(1,  "rst_idle", M_ALL, 16'h0, 3'd0, 1'b0, 1'b0, 8'd0);
    expect_at(20, "rst_stay", M_ALL, 16'h0, 3'd0, 1'b0, 1'b0, 8'd0);
    tick(20);
    spi_load = 1'b1; spi_phase_inc = 16'hABCD; spi_gain = 3'd1;
    expect_at(1, "post_rst_load", M_PH|M_G|M_B, 16'hABCD, 3'd1, 1'b0, 1'b0, 8'd0);
    tick(1); spi_load = 1'b0;
    tick(2);

    repeat (4) @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: never compared, due cycle %0d, now %0d", exp_q[0].name, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
